// File: rtl/alu_issue.sv
// alu_issue: RV32I ALU/branch decode and issue stage with a valid/ready handshake on both sides.
// Ports: clk, rst (async, active-high); in_valid/in_ready, instr, rs1_data, rs2_data;
//        out_valid/out_ready, A, B, S, illegal, illegal_cnt.
// Build option: ALU_ISSUE_SKID_EN adds a one-entry skid buffer and a registered in_ready.
module alu_issue #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      A,
  output logic [31:0]      B,
  output logic [5:0]       S,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  s;
    logic        ill;
  } op_t;

  op_t        dec;
  op_t        out_q;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       in_fire;
  logic       out_fire;
  logic       unused;

  assign opc      = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign unused   = ^{instr[19:15], instr[11:7]};
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  assign A       = out_q.a;
  assign B       = out_q.b;
  assign S       = out_q.s;
  assign illegal = out_q.ill;

  // Anything not recognised falls through as an illegal op with raw operands.
  always_comb begin
    dec.a   = rs1_data;
    dec.b   = rs2_data;
    dec.s   = 6'd0;
    dec.ill = 1'b1;
    case (opc)
      7'b0110011: begin
        if (f7 == 7'b0000000 ||
            (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
          dec.s   = {instr[30], f3, 2'b01};
          dec.ill = 1'b0;
        end
      end
      7'b0010011: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          // Shifts: only SRAI may carry funct7 = 0100000.
          if (f7 == 7'b0000000 ||
              (f3 == 3'b101 && f7 == 7'b0100000)) begin
            dec.b   = {27'd0, instr[24:20]};
            dec.s   = {f3[2] & instr[30], f3, 2'b01};
            dec.ill = 1'b0;
          end
        end else begin
          // Immediate bit 30 is data here, never the SUB select.
          dec.b   = {{20{instr[31]}}, instr[31:20]};
          dec.s   = {1'b0, f3, 2'b01};
          dec.ill = 1'b0;
        end
      end
      7'b1100011: begin
        if (f3[2:1] != 2'b01) begin
          dec.s   = {1'b1, f3, 2'b11};
          dec.ill = 1'b0;
        end
      end
      default: ;
    endcase
  end

`ifdef ALU_ISSUE_SKID_EN
  op_t  skid_q;
  logic skid_v;

  // Registered ready: upstream sees backpressure one cycle late,
  // the skid entry absorbs the op that was in flight.
  assign in_ready = !skid_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= '0;
      out_valid <= 1'b0;
      skid_q    <= '0;
      skid_v    <= 1'b0;
    end else if (skid_v) begin
      if (out_ready) begin
        out_q  <= skid_q;
        skid_v <= 1'b0;
      end
    end else if (in_fire) begin
      if (!out_valid || out_ready) begin
        out_q     <= dec;
        out_valid <= 1'b1;
      end else begin
        skid_q <= dec;
        skid_v <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else if (in_fire) begin
      out_q     <= dec;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (out_fire && out_q.ill) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule
